// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding and defaults for the BIST arbiter
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_RUN,
        ST_WAIT_END,
        ST_REPORT,
        ST_ABORT
    } bist_state_t;

    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_SIG_W   = 16;
    localparam logic [15:0] DEF_GOLDEN  = 16'hA5C3;
    localparam int unsigned DEF_TIMEOUT = 700;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin one-hot selector
module rr_pick
    import bist_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    localparam int unsigned LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [LW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [LW-1:0]   idx_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    int                base;
    int                pos;

    // Rotate so bit 0 is the requester just after last_i, then take the first set bit.
    always_comb begin
        dbl   = {req_i, req_i};
        base  = int'(last_i) + 1;
        rot   = dbl[base +: NREQ];
        found = 1'b0;
        pos   = 0;
        idx_o = '0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = base + j;
                if (pos >= int'(NREQ)) pos = pos - int'(NREQ);
                idx_o = LW'(pos);
            end
        end
        gnt_o = found ? (NREQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/bist_arbiter.sv
// rtl/bist_arbiter.sv - shares one BIST controller among NREQ requesters
module bist_arbiter
    import bist_pkg::*;
#(
    parameter int unsigned      NREQ    = DEF_NREQ,
    parameter int unsigned      SIG_W   = DEF_SIG_W,
    parameter logic [SIG_W-1:0] GOLDEN  = DEF_GOLDEN,
    parameter int unsigned      TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic             pass,
    output logic             timeout,
    output logic             ctrl_start,
    output logic             ctrl_reset,
    input  logic             ctrl_running,
    input  logic             ctrl_bist_end,
    input  logic [SIG_W-1:0] signature,
    output logic [7:0]       fail_count
);

    localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    bist_state_t     state_q;
    logic [NREQ-1:0] grant_q, done_q;
    logic [LW-1:0]   owner_q, last_q;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            pass_q, timeout_q, start_q, abort2_q;
    logic [7:0]      fail_q;
    logic            sig_ok, timeout_hit;
    logic [NREQ-1:0] pick_gnt;
    logic [LW-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    assign tcnt_d      = tcnt_q + TW'(1);
    assign timeout_hit = (tcnt_d == TW'(TIMEOUT));
    assign sig_ok      = (signature == GOLDEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            owner_q   <= '0;
            last_q    <= LW'(NREQ - 1);
            tcnt_q    <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
            abort2_q  <= 1'b0;
            fail_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    start_q <= 1'b0;
                    tcnt_q  <= '0;
                    state_q <= ST_WAIT_RUN;
                end
                ST_WAIT_RUN: begin
                    tcnt_q <= tcnt_d;
                    if (timeout_hit) begin
                        abort2_q <= 1'b0;
                        state_q  <= ST_ABORT;
                    end else if (ctrl_running) begin
                        state_q <= ST_WAIT_END;
                    end
                end
                ST_WAIT_END: begin
                    tcnt_q <= tcnt_d;
                    // Timeout wins over a bist_end arriving in the same cycle.
                    if (timeout_hit) begin
                        abort2_q <= 1'b0;
                        state_q  <= ST_ABORT;
                    end else if (ctrl_bist_end) begin
                        done_q    <= grant_q;
                        pass_q    <= sig_ok;
                        timeout_q <= 1'b0;
                        if (!sig_ok) fail_q <= sat_inc8(fail_q);
                        state_q <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    done_q  <= '0;
                    pass_q  <= 1'b0;
                    grant_q <= '0;
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                ST_ABORT: begin
                    if (!abort2_q) begin
                        abort2_q  <= 1'b1;
                        done_q    <= grant_q;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        fail_q    <= sat_inc8(fail_q);
                    end else begin
                        abort2_q  <= 1'b0;
                        done_q    <= '0;
                        timeout_q <= 1'b0;
                        grant_q   <= '0;
                        last_q    <= owner_q;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign ctrl_start = start_q;
    assign ctrl_reset = reset | (state_q == ST_ABORT);
    assign fail_count = fail_q;

endmodule

// File: tb/tb_bist_arbiter.sv
// tb/tb_bist_arbiter.sv - self-checking bench for bist_arbiter
module tb_bist_arbiter;

    localparam int          NREQ    = 4;
    localparam logic [15:0] GOLDEN  = 16'hA5C3;
    localparam int          TIMEOUT = 700;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  grant, done;
    logic        pass, timeout, ctrl_start, ctrl_reset;
    logic        ctrl_running = 1'b0;
    logic        ctrl_bist_end = 1'b0;
    logic [15:0] signature = '0;
    logic [7:0]  fail_count;

    int nvec = 0;
    int nfail = 0;

    bist_arbiter #(.NREQ(NREQ), .SIG_W(16), .GOLDEN(GOLDEN), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .grant         (grant),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .ctrl_start    (ctrl_start),
        .ctrl_reset    (ctrl_reset),
        .ctrl_running  (ctrl_running),
        .ctrl_bist_end (ctrl_bist_end),
        .signature     (signature),
        .fail_count    (fail_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int last);
        int idx = last;
        repeat (NREQ) begin
            idx = (idx + 1) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Stub BIST controller: runs run_len cycles after ctrl_start, optionally never finishes.
    int run_len = 650;
    bit never_end = 1'b0;
    int cs_cnt = 0;
    always @(negedge clk) begin
        if (ctrl_reset) begin
            ctrl_running = 1'b0; ctrl_bist_end = 1'b0; cs_cnt = 0;
        end else if (ctrl_start) begin
            ctrl_running = 1'b1; ctrl_bist_end = 1'b0; cs_cnt = 0;
        end else if (ctrl_running) begin
            cs_cnt++;
            if (!never_end && cs_cnt >= run_len) begin
                ctrl_bist_end = 1'b1; ctrl_running = 1'b0;
            end
        end else begin
            ctrl_bist_end = 1'b0;
        end
    end

    // Reference model: phase 0 = arbitration sample, 1 = run in flight, 2 = idle gap after done.
    int m_phase = 0, m_owner = 0, m_last = NREQ - 1, m_k = 0, m_fail = 0;
    int n_done = 0;
    int p;
    bit normal, fin, exp_pass;
    logic [3:0] d_grant;
    logic       d_pass, d_to;
    logic [7:0] d_fail;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            chk("rst_grant", grant, 0);
            chk("rst_done", done, 0);
            chk("rst_start", ctrl_start, 0);
            chk("rst_ctrl_reset", ctrl_reset, 1);
            chk("rst_fail_count", fail_count, 0);
            chk("rst_pass", pass, 0);
            chk("rst_timeout", timeout, 0);
            m_phase = 0; m_last = NREQ - 1; m_fail = 0;
        end else if (m_phase == 0) begin
            p = pick(req, m_last);
            chk("arb_grant", grant, (p < 0) ? 0 : (1 << p));
            chk("start_pulse", ctrl_start, (p >= 0) ? 1 : 0);
            chk("idle_done", done, 0);
            chk("idle_ctrl_reset", ctrl_reset, 0);
            if (p >= 0) begin m_owner = p; m_k = 0; m_phase = 1; end
        end else if (m_phase == 1) begin
            m_k++;
            normal = ctrl_bist_end && (m_k <= TIMEOUT);
            fin    = normal || (m_k == TIMEOUT + 2);
            chk("hold_grant", grant, 1 << m_owner);
            chk("single_start", ctrl_start, 0);
            chk("run_ctrl_reset", ctrl_reset,
                (!normal && (m_k == TIMEOUT + 1 || m_k == TIMEOUT + 2)) ? 1 : 0);
            chk("done_pulse", done, fin ? (1 << m_owner) : 0);
            if (fin) begin
                exp_pass = normal && (signature == GOLDEN);
                chk("done_pass", pass, exp_pass);
                chk("done_timeout", timeout, !normal);
                if (!exp_pass && m_fail < 255) m_fail++;
                chk("fail_count", fail_count, m_fail);
                d_grant = done; d_pass = pass; d_to = timeout; d_fail = fail_count;
                n_done++;
                m_last  = m_owner;
                m_phase = 2;
            end else begin
                chk("run_timeout", timeout, 0);
            end
        end else begin
            chk("gap_grant", grant, 0);
            chk("gap_done", done, 0);
            chk("gap_start", ctrl_start, 0);
            m_phase = 0;
        end
    end

    task automatic wait_done(input int bound, input string name);
        int start = n_done;
        bit got = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk);
            if (n_done != start) got = 1'b1;
        end
        chk(name, got, 1);
    endtask

    typedef struct {
        logic [3:0] req;
        bit         good;
        int         len;
        bit         never;
        logic [3:0] exp_grant;
        logic       exp_pass;
        logic       exp_to;
        int         exp_fail;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b0001, 1'b1, 650, 1'b0, 4'b0001, 1'b1, 1'b0, 0};
        tbl[1] = '{4'b1111, 1'b1, 5,   1'b0, 4'b0010, 1'b1, 1'b0, 0};
        tbl[2] = '{4'b1111, 1'b0, 5,   1'b0, 4'b0100, 1'b0, 1'b0, 1};
        tbl[3] = '{4'b1111, 1'b1, 5,   1'b0, 4'b1000, 1'b1, 1'b0, 1};
        tbl[4] = '{4'b1111, 1'b1, 5,   1'b0, 4'b0001, 1'b1, 1'b0, 1};
        tbl[5] = '{4'b1001, 1'b1, 5,   1'b0, 4'b1000, 1'b1, 1'b0, 1};
        tbl[6] = '{4'b1001, 1'b1, 5,   1'b0, 4'b0001, 1'b1, 1'b0, 1};
        tbl[7] = '{4'b0001, 1'b1, 5,   1'b0, 4'b0001, 1'b1, 1'b0, 1};
        tbl[8] = '{4'b0100, 1'b1, 5,   1'b1, 4'b0100, 1'b0, 1'b1, 2};

        repeat (3) @(negedge clk);
        chk("init_grant", grant, 0);
        chk("init_fail_count", fail_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req       = tbl[i].req;
            signature = tbl[i].good ? GOLDEN : 16'h0000;
            run_len   = tbl[i].len;
            never_end = tbl[i].never;
            @(negedge clk);
            chk("start_latency", ctrl_start, 1);
            wait_done(1000, "tbl_done_seen");
            chk("tbl_grant", d_grant, tbl[i].exp_grant);
            chk("tbl_pass", d_pass, tbl[i].exp_pass);
            chk("tbl_timeout", d_to, tbl[i].exp_to);
            chk("tbl_fail_count", d_fail, tbl[i].exp_fail);
        end

        // Reset 50 cycles into a run: run abandoned, arbitration restarts at requester 0.
        @(negedge clk);
        req = 4'b0100; never_end = 1'b0; run_len = 650; signature = GOLDEN;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_grant", grant, 0);
        chk("midrst_ctrl_reset", ctrl_reset, 1);
        chk("midrst_done", done, 0);
        reset = 1'b0;
        req = 4'b1111;
        run_len = 10;
        wait_done(1000, "after_rst_done_seen");
        chk("after_rst_grant", d_grant, 4'b0001);

        // Owner drops its request mid-run while another requester rises.
        @(negedge clk);
        req = 4'b0100; run_len = 20;
        repeat (6) @(negedge clk);
        req = 4'b0010;
        wait_done(1000, "drop_done_seen");
        chk("drop_owner_done", d_grant, 4'b0100);
        wait_done(1000, "next_done_seen");
        chk("next_owner_done", d_grant, 4'b0010);

        for (int r = 0; r < 40; r++) begin
            int  start;
            bit  got;
            @(negedge clk);
            req       = 4'($urandom_range(1, 15));
            run_len   = $urandom_range(2, 30);
            never_end = ($urandom_range(0, 9) == 0);
            start = n_done;
            got   = 1'b0;
            for (int c = 0; c < 1000 && !got; c++) begin
                @(negedge clk);
                signature = ($urandom_range(0, 1) == 1) ? GOLDEN : 16'($urandom);
                if (n_done != start) got = 1'b1;
                else if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            end
            chk("rand_done_seen", got, 1);
        end

        // Forced failures drive fail_count into saturation.
        @(negedge clk);
        req = 4'b0001; signature = 16'h0000; run_len = 2; never_end = 1'b0;
        for (int r = 0; r < 300; r++) wait_done(100, "sat_done_seen");
        chk("sat_fail_count", fail_count, 255);

        req = 4'b0000;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
